// File: rtl/fifo_pkt_reader.sv
// Drains a synchronous FIFO read port and frames length-prefixed packets
// into a valid/ready payload stream with a last-beat marker.
module fifo_pkt_reader #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             pkt_done,
    output logic             zero_len,
    output logic             busy
);

    typedef enum logic {HDR, PAY} state_t;

    localparam logic [2:0] CREDITS = 3'(BUF_DEPTH);

    state_t                  state;
    logic                    inflight;
    logic [WIDTH-1:0]        remaining;
    logic [1:0][WIDTH-1:0]   buf_data;
    logic [1:0]              buf_last;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              buf_count;
    logic [1:0]              pend;
    logic [1:0]              pend_next;

    logic                    pop;
    logic                    push;
    logic                    hdr_arr;
    logic                    hdr_nz;
    logic                    last_acc;
    logic [2:0]              credit;

    assign m_valid  = buf_count != 2'd0;
    assign m_data   = m_valid ? buf_data[rd_ptr] : '0;
    assign m_last   = m_valid & buf_last[rd_ptr];

    assign pop      = m_valid && m_ready;
    assign last_acc = pop && m_last;
    assign hdr_arr  = inflight && (state == HDR);
    assign hdr_nz   = hdr_arr && (fifo_data != '0);
    assign push     = inflight && (state == PAY);

    // Words still in flight count against buffer space so nothing can overflow.
    assign credit   = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, pop};
    assign fifo_rd  = rst_n && !fifo_empty && (credit < CREDITS);

    // Packets whose header is consumed but whose last beat is not yet accepted.
    assign pend_next = pend + {1'b0, hdr_nz} - {1'b0, last_acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HDR;
            inflight  <= 1'b0;
            remaining <= '0;
            buf_data  <= '0;
            buf_last  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            buf_count <= 2'd0;
            pend      <= 2'd0;
            pkt_done  <= 1'b0;
            zero_len  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            inflight  <= fifo_rd;
            pkt_done  <= last_acc;
            zero_len  <= hdr_arr && (fifo_data == '0);
            pend      <= pend_next;
            busy      <= pend_next != 2'd0;
            buf_count <= buf_count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                buf_data[wr_ptr] <= fifo_data;
                buf_last[wr_ptr] <= remaining == WIDTH'(1);
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case (1'b1)
                state == HDR: begin
                    if (hdr_nz) begin
                        remaining <= fifo_data;
                        state     <= PAY;
                    end
                end
                state == PAY: begin
                    if (inflight) begin
                        remaining <= remaining - WIDTH'(1);
                        if (remaining == WIDTH'(1)) begin
                            state <= HDR;
                        end
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: behavioural FIFO, beat scoreboard,
// packet vector table and hand-written stall/reset sequences.
module tb_fifo_pkt_reader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_rd;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         pkt_done;
    logic         zero_len;
    logic         busy;

    fifo_pkt_reader #(.WIDTH(W), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .pkt_done(pkt_done), .zero_len(zero_len),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    typedef struct {
        int           len;
        logic [W-1:0] base;
        int           exp_done;
        int           exp_zero;
        int           exp_busy;
    } vec_t;

    beat_t        sb[$];
    logic [W-1:0] fq[$];
    int           beat_cyc[$];
    int           done_cyc[$];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, dones = 0, zeros = 0, busy_cyc = 0;
    logic  pv = 1'b0;
    beat_t pb = '0;
    logic  rd_now;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endfunction

    task automatic put(input logic [W-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic expect_beat(input logic [W-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        sb.push_back(b);
    endtask

    // One clock: monitor at negedge, FIFO model update just after posedge.
    task automatic step();
        beat_t e;
        @(negedge clk);
        if (rst_n) begin
            chk("rd_on_empty", int'(fifo_rd && fifo_empty), 0);
            if (pv) begin
                chk("hold_valid", int'(m_valid), 1);
                chk("hold_data", int'(m_data), int'(pb.data));
                chk("hold_last", int'(m_last), int'(pb.last));
            end
            if (m_valid && m_ready) begin
                beat_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("extra_beat", int'(m_data), -1);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", int'(m_data), int'(e.data));
                    chk("beat_last", int'(m_last), int'(e.last));
                end
            end
            if (pkt_done) begin
                dones++;
                done_cyc.push_back(cyc);
            end
            if (zero_len) zeros++;
            if (busy) busy_cyc++;
            pv = m_valid && !m_ready;
            pb = {m_last, m_data};
        end else begin
            pv = 1'b0;
        end
        rd_now = fifo_rd;
        @(posedge clk);
        cyc++;
        #1;
        if (rd_now && fq.size() != 0) fifo_data = fq.pop_front();
        fifo_empty = fq.size() == 0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((sb.size() != 0 || fq.size() != 0) && t < 2000) begin
            step();
            t++;
        end
        chk({name, "_timeout"}, int'(t < 2000), 1);
        repeat (4) step();
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_fifo_rd"}, int'(fifo_rd), 0);
        chk({name, "_m_valid"}, int'(m_valid), 0);
        chk({name, "_m_data"}, int'(m_data), 0);
        chk({name, "_m_last"}, int'(m_last), 0);
        chk({name, "_pkt_done"}, int'(pkt_done), 0);
        chk({name, "_zero_len"}, int'(zero_len), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    vec_t vecs[5];

    initial begin
        int d0, z0, b0, n0, t, gap, maxgap;
        vecs[0] = '{len: 1,   base: 8'h10, exp_done: 1, exp_zero: 0, exp_busy: 2};
        vecs[1] = '{len: 0,   base: 8'h00, exp_done: 0, exp_zero: 1, exp_busy: 0};
        vecs[2] = '{len: 4,   base: 8'h20, exp_done: 1, exp_zero: 0, exp_busy: 5};
        vecs[3] = '{len: 2,   base: 8'hFE, exp_done: 1, exp_zero: 0, exp_busy: 3};
        vecs[4] = '{len: 255, base: 8'h00, exp_done: 1, exp_zero: 0, exp_busy: 256};

        #1;
        check_zero_outputs("reset");
        repeat (2) step();
        rst_n = 1'b1;
        m_ready = 1'b1;
        step();

        foreach (vecs[i]) begin
            d0 = dones; z0 = zeros; b0 = busy_cyc; n0 = beat_cyc.size();
            put(W'(vecs[i].len));
            for (int k = 0; k < vecs[i].len; k++) begin
                put(vecs[i].base + W'(k));
                expect_beat(vecs[i].base + W'(k), k == vecs[i].len - 1);
            end
            drain("vec");
            chk("vec_done", dones - d0, vecs[i].exp_done);
            chk("vec_zero", zeros - z0, vecs[i].exp_zero);
            chk("vec_busy", busy_cyc - b0, vecs[i].exp_busy);
            if (vecs[i].len > 0 && beat_cyc.size() > n0)
                chk("vec_span", beat_cyc[$] - beat_cyc[n0], vecs[i].len - 1);
        end

        d0 = dones; n0 = beat_cyc.size();
        put(8'h03); put(8'hAA); put(8'hBB); put(8'hCC);
        expect_beat(8'hAA, 0); expect_beat(8'hBB, 0); expect_beat(8'hCC, 1);
        drain("basic");
        chk("basic_done", dones - d0, 1);
        if (beat_cyc.size() == n0 + 3) begin
            chk("basic_span", beat_cyc[$] - beat_cyc[n0], 2);
            chk("basic_done_lat", done_cyc[$] - beat_cyc[$], 1);
        end else chk("basic_beats", beat_cyc.size() - n0, 3);

        m_ready = 1'b0;
        put(8'h03); put(8'hAA); put(8'hBB); put(8'hCC);
        expect_beat(8'hAA, 0); expect_beat(8'hBB, 0); expect_beat(8'hCC, 1);
        t = 0;
        while (!m_valid && t < 20) begin step(); t++; end
        chk("stall_valid", int'(m_valid), 1);
        repeat (4) step();
        chk("stall_fq_left", fq.size(), 1);
        chk("stall_data", int'(m_data), 8'hAA);
        m_ready = 1'b1;
        drain("stall");

        d0 = dones; z0 = zeros; b0 = busy_cyc;
        put(8'h00); put(8'h01); put(8'h55);
        expect_beat(8'h55, 1);
        drain("zero");
        chk("zero_pulses", zeros - z0, 1);
        chk("zero_busy", busy_cyc - b0, 2);
        chk("zero_done", dones - d0, 1);

        d0 = dones; n0 = beat_cyc.size();
        put(8'h02); put(8'h11); put(8'h22); put(8'h01); put(8'h33);
        expect_beat(8'h11, 0); expect_beat(8'h22, 1); expect_beat(8'h33, 1);
        drain("b2b");
        chk("b2b_done", dones - d0, 2);
        maxgap = 0;
        for (int k = n0 + 1; k < beat_cyc.size(); k++) begin
            gap = beat_cyc[k] - beat_cyc[k-1];
            if (gap > maxgap) maxgap = gap;
        end
        chk("b2b_gap_ok", int'(maxgap <= 2 && maxgap >= 1), 1);

        put(8'h04); put(8'h01); put(8'h02);
        expect_beat(8'h01, 0); expect_beat(8'h02, 0);
        expect_beat(8'h03, 0); expect_beat(8'h04, 1);
        repeat (6) step();
        chk("under_busy", int'(busy), 1);
        chk("under_valid", int'(m_valid), 0);
        chk("under_left", sb.size(), 2);
        put(8'h03); put(8'h04);
        drain("under");
        chk("under_idle", int'(busy), 0);

        b0 = beat_cyc.size();
        put(8'h05);
        for (int k = 0; k < 5; k++) put(8'hA0 + W'(k));
        expect_beat(8'hA0, 0); expect_beat(8'hA1, 0);
        t = 0;
        while (beat_cyc.size() - b0 < 2 && t < 40) begin step(); t++; end
        chk("rst_pre_beats", beat_cyc.size() - b0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        fq.delete();
        sb.delete();
        fifo_empty = 1'b1;
        step();
        rst_n = 1'b1;
        d0 = dones;
        put(8'h01); put(8'h77);
        expect_beat(8'h77, 1);
        drain("post_rst");
        chk("post_rst_done", dones - d0, 1);
        chk("post_rst_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
